// File: rtl/resp_demux_pkg.sv
// Shared constants for the response demultiplexer and its tag tracker.
// PORT_A/PORT_B give the encoding of req_sel and of each recorded tag.
package resp_demux_pkg;

    localparam logic PORT_A    = 1'b0;
    localparam logic PORT_B    = 1'b1;
    localparam int   DEFAULT_N = 32;

endpackage

// File: rtl/tag_fifo.sv
// In-order tracker of 1-bit destination tags, one entry per outstanding bus request.
// A push while full and a pop while empty are ignored, so callers may present them freely.
module tag_fifo #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pushTag,
    input  logic          pop,
    output logic          headTag,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0] tags;
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign headTag = tags[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) tags[wrPtr] <= pushTag;
    end

endmodule

// File: rtl/resp_demux.sv
// Steers a single in-order memory response stream to the fetch (A) or load/store (B) port,
// using the destination recorded when each request was issued.
module resp_demux
    import resp_demux_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_sel,
    output logic          req_ready,
    input  logic          rsp_valid,
    input  logic [N-1:0]  rsp_data,
    output logic          rsp_ready,
    output logic          a_valid,
    output logic [N-1:0]  a_data,
    input  logic          a_ready,
    output logic          b_valid,
    output logic [N-1:0]  b_data,
    input  logic          b_ready,
    output logic [CW-1:0] outstanding,
    output logic          err_unexpected
);

    logic headTag;
    logic tagsFull;
    logic tagsEmpty;
    logic destReady;
    logic popTag;
    logic loadA;
    logic loadB;

    tag_fifo #(.DEPTH(DEPTH)) u_tags (
        .clk     (clk),
        .rst     (rst),
        .push    (req_valid),
        .pushTag (req_sel),
        .pop     (popTag),
        .headTag (headTag),
        .count   (outstanding),
        .full    (tagsFull),
        .empty   (tagsEmpty)
    );

    assign req_ready = !tagsFull;

    // A response may land if its holding register is free or is being drained this cycle.
    assign destReady = (headTag == PORT_A) ? (!a_valid || a_ready) : (!b_valid || b_ready);
    assign rsp_ready = tagsEmpty ? 1'b1 : destReady;
    assign popTag    = rsp_valid && rsp_ready && !tagsEmpty;
    assign loadA     = popTag && (headTag == PORT_A);
    assign loadB     = popTag && (headTag == PORT_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_data  <= '0;
        end else if (loadA) begin
            a_valid <= 1'b1;
            a_data  <= rsp_data;
        end else if (a_valid && a_ready) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_data  <= '0;
        end else if (loadB) begin
            b_valid <= 1'b1;
            b_data  <= rsp_data;
        end else if (b_valid && b_ready) begin
            b_valid <= 1'b0;
        end
    end

    // Responses with nothing outstanding are swallowed; the flag stays up until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_unexpected <= 1'b0;
        end else if (rsp_valid && tagsEmpty) begin
            err_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_resp_demux.sv
// Randomised scoreboard bench for resp_demux: a queue-based model predicts handshakes,
// and a monitor compares each port's presented data against the expected response order.
module tb_resp_demux;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_sel = 1'b0;
    logic          req_ready;
    logic          rsp_valid = 1'b0;
    logic [N-1:0]  rsp_data = '0;
    logic          rsp_ready;
    logic          a_valid;
    logic [N-1:0]  a_data;
    logic          a_ready = 1'b0;
    logic          b_valid;
    logic [N-1:0]  b_data;
    logic          b_ready = 1'b0;
    logic [CW-1:0] outstanding;
    logic          err_unexpected;

    int vectors = 0;
    int miscompares = 0;

    // Model state: recorded destinations, responses owed to each port, sticky error.
    bit           pending[$];
    logic [N-1:0] expA[$];
    logic [N-1:0] expB[$];
    bit           expErr = 1'b0;

    resp_demux #(.N(N), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_sel        (req_sel),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_ready      (rsp_ready),
        .a_valid        (a_valid),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Checks control outputs against the model, then advances the model across the coming edge.
    task automatic checkOutput();
        bit expRspReady;
        bit doPush;
        bit doPop;
        if (pending.size() == 0)       expRspReady = 1'b1;
        else if (pending[0] == 1'b0)   expRspReady = (expA.size() == 0) || a_ready;
        else                           expRspReady = (expB.size() == 0) || b_ready;

        compare("req_ready", N'(req_ready), N'(pending.size() < DEPTH));
        compare("outstanding", N'(outstanding), N'(pending.size()));
        compare("err_unexpected", N'(err_unexpected), N'(expErr));
        compare("rsp_ready", N'(rsp_ready), N'(expRspReady));
        compare("a_valid", N'(a_valid), N'(expA.size() != 0));
        compare("b_valid", N'(b_valid), N'(expB.size() != 0));

        if (rst) begin
            pending.delete();
            expA.delete();
            expB.delete();
            expErr = 1'b0;
        end else begin
            doPop  = rsp_valid && expRspReady && (pending.size() != 0);
            doPush = req_valid && (pending.size() < DEPTH);
            if (rsp_valid && pending.size() == 0) expErr = 1'b1;
            if (doPop) begin
                if (pending.pop_front() == 1'b0) expA.push_back(rsp_data);
                else                             expB.push_back(rsp_data);
            end
            if (doPush) pending.push_back(req_sel);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit rv, input bit rs, input bit sv,
                                 input logic [N-1:0] d, input bit ar, input bit br);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = rv;
        req_sel   = rs;
        rsp_valid = sv;
        rsp_data  = d;
        a_ready   = ar;
        b_ready   = br;
        #3;
        checkOutput();
    endtask

    // Monitor: whenever a port holds data it must match the oldest response owed to that port.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (a_valid === 1'b1) begin
                if (expA.size() == 0) compare("a_data_unexpected", a_data, 'x);
                else begin
                    compare("a_data", a_data, expA[0]);
                    if (a_ready) void'(expA.pop_front());
                end
            end
            if (b_valid === 1'b1) begin
                if (expB.size() == 0) compare("b_data_unexpected", b_data, 'x);
                else begin
                    compare("b_data", b_data, expB[0]);
                    if (b_ready) void'(expB.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset and idle.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);

        // Three requests A,B,A answered in order with both ports ready.
        applyStimulus(0, 1, 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 1, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 32'h11, 1, 1);
        applyStimulus(0, 0, 0, 1, 32'h22, 1, 1);
        applyStimulus(0, 0, 0, 1, 32'h33, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);

        // Fill the tag FIFO, try a fifth request, then free one slot.
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, i[0], 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 32'h44, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 32'h50 + i, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);

        // Port B backpressure holds off the next B response until b_ready rises.
        applyStimulus(0, 1, 1, 0, 0, 1, 0);
        applyStimulus(0, 1, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 32'h55, 1, 0);
        applyStimulus(0, 0, 0, 1, 32'hAA, 1, 0);
        applyStimulus(0, 0, 0, 1, 32'hAA, 1, 0);
        applyStimulus(0, 0, 0, 1, 32'hAA, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);

        // Response with nothing outstanding; flag must stick.
        applyStimulus(0, 0, 0, 1, 32'hDEAD, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1);

        // Reset with work in flight, then a stray response.
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h77, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h88, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 6),
                          N'($urandom),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0));
        end

        // Drain whatever is still outstanding.
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, (pending.size() != 0), N'($urandom), 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
